// File: rtl/mandel_iterator.sv
// Mandelbrot escape-time engine for one pixel: maps (x, y) to c, iterates z <- z^2 + c in signed fixed point.
// Optional MANDEL_RESTART_EN: a start request during SETUP/ITER aborts the current point and restarts.
module mandel_iterator #(
    parameter int HBP = 32,
    parameter int HBS = 32,
    parameter int HBI = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [11:0]           x,
    input  logic [11:0]           y,
    input  logic [HBS-1:0]        re_scale,
    input  logic [HBS-1:0]        im_scale,
    input  logic signed [HBP-1:0] re_start,
    input  logic signed [HBP-1:0] im_start,
    input  logic [HBI-1:0]        max_iterations,
    output logic                  ready,
    output logic                  busy,
    output logic [HBI-1:0]        iteration,
    output logic                  escaped
);
    localparam int FRAC = HBP - 3;
    localparam int PW   = 12 + HBS;
    localparam int SW   = (PW > HBP) ? PW : HBP;
    localparam int AW   = HBP + 4;
    localparam logic signed [2*HBP:0] LIMIT = (2*HBP+1)'(1) << (2*FRAC + 2);

    typedef enum logic [1:0] {IDLE, SETUP, ITER, DONE} state_t;
    state_t state, state_next;

    logic                  capture;
    logic [11:0]           x_r, y_r;
    logic [HBS-1:0]        re_scale_r, im_scale_r;
    logic signed [HBP-1:0] re_start_r, im_start_r;
    logic [HBI-1:0]        max_r;
    logic signed [HBP-1:0] re_z, im_z, re_c, im_c;

    logic [PW-1:0]          re_prod, im_prod;
    logic [SW-1:0]          re_map, im_map;
    logic signed [2*HBP-1:0] re_sq, im_sq, re_im;
    logic signed [2*HBP:0]   mag;
    logic signed [AW-1:0]    re_sum, im_sum;
    logic                    esc, budget_hit;

    // Clamp an extended sum into [-4.0, 4.0 - 1 LSB] so z never wraps.
    function automatic logic signed [HBP-1:0] sat(input logic signed [AW-1:0] v);
        if (v[AW-1:HBP-1] == '0 || v[AW-1:HBP-1] == '1)
            return v[HBP-1:0];
        else if (v[AW-1])
            return {1'b1, {(HBP-1){1'b0}}};
        else
            return {1'b0, {(HBP-1){1'b1}}};
    endfunction

    assign re_prod = PW'(x_r) * PW'(re_scale_r);
    assign im_prod = PW'(y_r) * PW'(im_scale_r);
    assign re_map  = SW'(re_start_r) + SW'(re_prod);
    assign im_map  = SW'(im_start_r) + SW'(im_prod);

    assign re_sq = (2*HBP)'(re_z) * (2*HBP)'(re_z);
    assign im_sq = (2*HBP)'(im_z) * (2*HBP)'(im_z);
    assign re_im = (2*HBP)'(re_z) * (2*HBP)'(im_z);
    assign mag   = (2*HBP+1)'(re_sq) + (2*HBP+1)'(im_sq);
    assign esc   = mag > LIMIT;
    assign budget_hit = (iteration == max_r);

    assign re_sum = AW'(re_sq >>> FRAC) - AW'(im_sq >>> FRAC) + AW'(re_c);
    assign im_sum = (AW'(re_im >>> FRAC) <<< 1) + AW'(im_c);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ITER;
            ITER: begin
                if (esc || budget_hit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
`ifdef MANDEL_RESTART_EN
        if ((state == SETUP || state == ITER) && start) begin
            capture    = 1'b1;
            state_next = SETUP;
        end
`endif
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = ~ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_r        <= '0;
            y_r        <= '0;
            re_scale_r <= '0;
            im_scale_r <= '0;
            re_start_r <= '0;
            im_start_r <= '0;
            max_r      <= '0;
            re_c       <= '0;
            im_c       <= '0;
            re_z       <= '0;
            im_z       <= '0;
            iteration  <= '0;
            escaped    <= 1'b0;
        end else begin
            if (capture) begin
                x_r        <= x;
                y_r        <= y;
                re_scale_r <= re_scale;
                im_scale_r <= im_scale;
                re_start_r <= re_start;
                im_start_r <= im_start;
                max_r      <= max_iterations;
            end
            if (state == SETUP && !capture) begin
                re_c      <= re_map[HBP-1:0];
                im_c      <= im_map[HBP-1:0];
                re_z      <= '0;
                im_z      <= '0;
                iteration <= '0;
                escaped   <= 1'b0;
            end else if (state == ITER && !capture) begin
                if (esc) begin
                    escaped <= 1'b1;
                end else if (!budget_hit) begin
                    re_z      <= sat(re_sum);
                    im_z      <= sat(im_sum);
                    iteration <= iteration + HBI'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mandel_iterator.sv
// Directed-vector bench for mandel_iterator; expectations hand-derived for HBP = 32, FRAC = 29.
module tb_mandel_iterator;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [11:0] x, y;
    logic [31:0] re_scale, im_scale;
    logic signed [31:0] re_start, im_start;
    logic [31:0] max_iterations;
    logic        ready, busy, escaped;
    logic [31:0] iteration;

    int tests = 0;
    int fails = 0;

    mandel_iterator #(.HBP(32), .HBS(32), .HBI(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .x(x), .y(y),
        .re_scale(re_scale), .im_scale(im_scale),
        .re_start(re_start), .im_start(im_start),
        .max_iterations(max_iterations),
        .ready(ready), .busy(busy), .iteration(iteration), .escaped(escaped)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request on the next negedge; returns just after the accepting edge E.
    task automatic launch(input logic [31:0] rs, input logic [31:0] is, input logic [11:0] xx,
                          input logic [11:0] yy, input logic [31:0] rsc, input logic [31:0] isc,
                          input logic [31:0] mx, input bit hold);
        @(negedge CLK);
        re_start = rs; im_start = is; x = xx; y = yy;
        re_scale = rsc; im_scale = isc; max_iterations = mx;
        start = 1'b1;
        @(posedge CLK); #1;
        if (!hold) start = 1'b0;
    endtask

    // n counts edges after E; ready is observed high just after edge E+n.
    task automatic wait_ready(inout int n);
        while (!ready && n < 5000) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [5:0] seq;
        RST_N = 1'b0; start = 1'b0; x = '0; y = '0;
        re_scale = '0; im_scale = '0; re_start = '0; im_start = '0; max_iterations = '0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_iter", 64'(iteration), 64'd0);
        check("rst_esc", 64'(escaped), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b1;

        // c = 1.0: z = 0, 1, 2, then saturates -> escape after 3 updates
        launch(32'h2000_0000, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd100, 1'b0);
        check("esc_busy", 64'(busy), 64'd1);
        n = 0; wait_ready(n);
        check("esc_lat", 64'(n), 64'd5);
        check("esc_iter", 64'(iteration), 64'd3);
        check("esc_flag", 64'(escaped), 64'd1);

        // c = -2.0: z settles at 2.0, |z|^2 == 4.0 exactly must not escape
        launch(32'hC000_0000, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd50, 1'b0);
        n = 0; wait_ready(n);
        check("bnd_lat", 64'(n), 64'd52);
        check("bnd_iter", 64'(iteration), 64'd50);
        check("bnd_esc", 64'(escaped), 64'd0);

        // zero budget, start held: ready pattern 0,0,1,0,0,1 after edges E..E+5
        launch(32'h0, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd0, 1'b1);
        seq[0] = ready;
        for (int i = 1; i < 6; i++) begin
            @(posedge CLK); #1;
            seq[i] = ready;
        end
        @(negedge CLK); start = 1'b0;
        check("b2b_ready_seq", 64'(seq), 64'b100100);
        check("b2b_iter", 64'(iteration), 64'd0);
        check("b2b_esc", 64'(escaped), 64'd0);

        // x = 320 at 1/256 step from -1.0 gives re_c = 0.25 (bounded)
        launch(32'hE000_0000, 32'h0, 12'd320, 12'd0, 32'h0020_0000, 32'h0, 32'd1000, 1'b0);
        n = 0; wait_ready(n);
        check("map_lat", 64'(n), 64'd1002);
        check("map_iter", 64'(iteration), 64'd1000);
        check("map_esc", 64'(escaped), 64'd0);

        // c = 1 + i via y = 256 at 1/256: z1 = 1+i, z2 = 1+3i escapes
        launch(32'h2000_0000, 32'h0, 12'd0, 12'd256, 32'h0, 32'h0020_0000, 32'd10, 1'b0);
        n = 0; wait_ready(n);
        check("cplx_lat", 64'(n), 64'd4);
        check("cplx_iter", 64'(iteration), 64'd2);
        check("cplx_esc", 64'(escaped), 64'd1);

        // asynchronous reset in the middle of ITER
        launch(32'h0, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd100, 1'b0);
        repeat (5) begin @(posedge CLK); #1; end
        check("mid_iter_progress", 64'(iteration), 64'd4);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_iter", 64'(iteration), 64'd0);
        check("mid_rst_esc", 64'(escaped), 64'd0);
        @(negedge CLK); RST_N = 1'b1;
        launch(32'h2000_0000, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd100, 1'b0);
        n = 0; wait_ready(n);
        check("post_rst_lat", 64'(n), 64'd5);
        check("post_rst_iter", 64'(iteration), 64'd3);

        // second request at E+10 while the first point (c = 0) is busy
        launch(32'h0, 32'h0, 12'd0, 12'd0, 32'h0, 32'h0, 32'd100, 1'b0);
        n = 0;
        repeat (9) begin @(posedge CLK); #1; n++; end
        @(negedge CLK);
        re_start = 32'h2000_0000;
        start = 1'b1;
        @(posedge CLK); #1; n++;
        start = 1'b0;
        wait_ready(n);
`ifdef MANDEL_RESTART_EN
        check("busy_start_lat", 64'(n), 64'd15);
        check("busy_start_iter", 64'(iteration), 64'd3);
        check("busy_start_esc", 64'(escaped), 64'd1);
`else
        check("busy_start_lat", 64'(n), 64'd102);
        check("busy_start_iter", 64'(iteration), 64'd100);
        check("busy_start_esc", 64'(escaped), 64'd0);
        repeat (4) @(posedge CLK); #1;
        check("busy_start_dropped", 64'(ready), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
